// File: rtl/wb_arbiter_pkg.sv
// Shared core constants for the writeback arbiter and its round-robin picker.
package wb_arbiter_pkg;
  localparam int XLEN         = 32;
  localparam int REG_AW       = 5;
  localparam int NUM_WB_PORTS = 4;
  localparam int NUM_WB_REQ   = 6;

  // Single-step modular wrap; idx is never more than 2*n-1 here.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction
endpackage

// File: rtl/wb_rr_pick.sv
// Combinational rotating scan: grants up to NPORT nonzero-address requests,
// skipping same-cycle address conflicts; x0 writes are accepted without a port.
module wb_rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ  = NUM_WB_REQ,
  parameter int NPORT = NUM_WB_PORTS,
  parameter int AW    = REG_AW,
  parameter int PW    = 3
) (
  input  logic               en,
  input  logic [NREQ-1:0]    valid,
  input  logic [NREQ*AW-1:0] waddr,
  input  logic [PW-1:0]      ptr,
  output logic [NREQ-1:0]    ready,
  output logic [NPORT-1:0]   port_en,
  output logic [PW-1:0]      port_sel [NPORT],
  output logic [PW-1:0]      ptr_nxt
);
  logic [AW-1:0] port_addr [NPORT];

  always_comb begin
    int            n_grant;
    int            idx;
    logic [AW-1:0] cur_addr;
    logic          clash;
    ready    = '0;
    port_en  = '0;
    ptr_nxt  = ptr;
    n_grant  = 0;
    idx      = 0;
    cur_addr = '0;
    clash    = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      port_sel[k]  = '0;
      port_addr[k] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      idx      = wrap_idx(int'(ptr) + i, NREQ);
      cur_addr = waddr[idx*AW +: AW];
      clash    = 1'b0;
      for (int k = 0; k < NPORT; k++) begin
        if (k < n_grant && port_addr[k] == cur_addr) clash = 1'b1;
      end
      if (en && valid[idx]) begin
        if (cur_addr == '0) begin
          ready[idx] = 1'b1;
        end else if (n_grant < NPORT && !clash) begin
          ready[idx] = 1'b1;
          for (int k = 0; k < NPORT; k++) begin
            if (k == n_grant) begin
              port_en[k]   = 1'b1;
              port_sel[k]  = PW'(idx);
              port_addr[k] = cur_addr;
            end
          end
          // Next scan starts just past the most recent real grant.
          ptr_nxt = PW'(wrap_idx(idx + 1, NREQ));
          n_grant = n_grant + 1;
        end
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: up to four register-file writes per cycle from NREQ
// execution units with rotating priority; write ports are registered (latency 1).
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ  = NUM_WB_REQ,
  parameter int NPORT = NUM_WB_PORTS,
  parameter int AW    = REG_AW,
  parameter int DW    = XLEN
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_valid,
  input  logic [NREQ*AW-1:0] i_waddr,
  input  logic [NREQ*DW-1:0] i_wdata,
  output logic [NREQ-1:0]    o_ready,
  output logic               o_we0,
  output logic               o_we1,
  output logic               o_we2,
  output logic               o_we3,
  output logic [AW-1:0]      o_waddr0,
  output logic [AW-1:0]      o_waddr1,
  output logic [AW-1:0]      o_waddr2,
  output logic [AW-1:0]      o_waddr3,
  output logic [DW-1:0]      o_wdata0,
  output logic [DW-1:0]      o_wdata1,
  output logic [DW-1:0]      o_wdata2,
  output logic [DW-1:0]      o_wdata3
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NPORT-1:0] port_en;
  logic [PW-1:0]    port_sel [NPORT];
  logic [NPORT-1:0] we_q, we_d;
  logic [AW-1:0]    waddr_q [NPORT];
  logic [AW-1:0]    waddr_d [NPORT];
  logic [DW-1:0]    wdata_q [NPORT];
  logic [DW-1:0]    wdata_d [NPORT];

  wb_rr_pick #(
    .NREQ (NREQ),
    .NPORT(NPORT),
    .AW   (AW),
    .PW   (PW)
  ) u_pick (
    .en      (!i_rst),
    .valid   (i_valid),
    .waddr   (i_waddr),
    .ptr     (ptr_q),
    .ready   (o_ready),
    .port_en (port_en),
    .port_sel(port_sel),
    .ptr_nxt (ptr_d)
  );

  // Idle ports carry zero address/data so downstream never sees stale values.
  always_comb begin
    we_d = port_en;
    for (int k = 0; k < NPORT; k++) begin
      waddr_d[k] = '0;
      wdata_d[k] = '0;
      if (port_en[k]) begin
        waddr_d[k] = i_waddr[int'(port_sel[k])*AW +: AW];
        wdata_d[k] = i_wdata[int'(port_sel[k])*DW +: DW];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= '0;
      we_q  <= '0;
      for (int k = 0; k < NPORT; k++) begin
        waddr_q[k] <= '0;
        wdata_q[k] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_we0    = we_q[0];
  assign o_we1    = we_q[1];
  assign o_we2    = we_q[2];
  assign o_we3    = we_q[3];
  assign o_waddr0 = waddr_q[0];
  assign o_waddr1 = waddr_q[1];
  assign o_waddr2 = waddr_q[2];
  assign o_waddr3 = waddr_q[3];
  assign o_wdata0 = wdata_q[0];
  assign o_wdata1 = wdata_q[1];
  assign o_wdata2 = wdata_q[2];
  assign o_wdata3 = wdata_q[3];
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic
// checked against per-requester scoreboard queues.
module tb_wb_arbiter;
  localparam int NREQ  = 6;
  localparam int NPORT = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    valid;
  logic [NREQ*AW-1:0] waddr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    ready;
  logic               we0, we1, we2, we3;
  logic [AW-1:0]      wa0, wa1, wa2, wa3;
  logic [DW-1:0]      wd0, wd1, wd2, wd3;

  logic [NPORT-1:0]   we_v;
  logic [AW-1:0]      wa_v [NPORT];
  logic [DW-1:0]      wd_v [NPORT];

  logic [NPORT-1:0]   ew;
  logic [AW-1:0]      ea [NPORT];
  logic [DW-1:0]      ed [NPORT];

  logic [AW+DW-1:0]   sbq [NREQ][$];
  int                 wait_c [NREQ];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .i_waddr (waddr),
    .i_wdata (wdata),
    .o_ready (ready),
    .o_we0   (we0),
    .o_we1   (we1),
    .o_we2   (we2),
    .o_we3   (we3),
    .o_waddr0(wa0),
    .o_waddr1(wa1),
    .o_waddr2(wa2),
    .o_waddr3(wa3),
    .o_wdata0(wd0),
    .o_wdata1(wd1),
    .o_wdata2(wd2),
    .o_wdata3(wd3)
  );

  assign we_v    = {we3, we2, we1, we0};
  assign wa_v[0] = wa0;
  assign wa_v[1] = wa1;
  assign wa_v[2] = wa2;
  assign wa_v[3] = wa3;
  assign wd_v[0] = wd0;
  assign wd_v[1] = wd1;
  assign wd_v[2] = wd2;
  assign wd_v[3] = wd3;

  task automatic clear_req;
    valid = '0;
    waddr = '0;
    wdata = '0;
  endtask

  task automatic set_req(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    valid[r]           = 1'b1;
    waddr[r*AW +: AW]  = a;
    wdata[r*DW +: DW]  = d;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_req();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    for (int r = 0; r < NREQ; r++) set_req(r, AW'(r + 1), DW'(r));
    #1;
    n_tests++;
    if (ready !== '0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 000000", ready);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NPORT; k++) begin
      n_tests++;
      if ({we_v[k], wa_v[k], wd_v[k]} !== '0) begin
        n_fail++;
        $display("FAIL reset_port%0d: got we=%b a=%0d d=%h want zeros", k, we_v[k], wa_v[k], wd_v[k]);
      end
    end
    n_tests++;
    if (dut.ptr_q !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ptr: got %0d want 0", dut.ptr_q);
    end
    $display("[TB] reset: ready=%b we=%b", ready, we_v);
    rst = 1'b0;
    clear_req();
  endtask

  task automatic test_two_req;
    do_reset();
    set_req(0, 5'd3, 32'hA);
    set_req(1, 5'd4, 32'hB);
    #1;
    n_tests++;
    if (ready !== 6'b000011) begin
      n_fail++;
      $display("FAIL two_req_ready: got %b want 000011", ready);
    end
    @(posedge clk);
    #1;
    clear_req();
    ew = 4'b0011;
    ea = '{5'd3, 5'd4, 5'd0, 5'd0};
    ed = '{32'hA, 32'hB, 32'h0, 32'h0};
    for (int k = 0; k < NPORT; k++) begin
      n_tests++;
      if ({we_v[k], wa_v[k], wd_v[k]} !== {ew[k], ea[k], ed[k]}) begin
        n_fail++;
        $display("FAIL two_req_port%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                 k, we_v[k], wa_v[k], wd_v[k], ew[k], ea[k], ed[k]);
      end
    end
    n_tests++;
    if (dut.ptr_q !== 3'd2) begin
      n_fail++;
      $display("FAIL two_req_ptr: got %0d want 2", dut.ptr_q);
    end
    $display("[TB] two_req: we=%b a0=%0d a1=%0d ptr=%0d", we_v, wa0, wa1, dut.ptr_q);
  endtask

  task automatic test_all_six;
    do_reset();
    for (int r = 0; r < NREQ; r++) set_req(r, AW'(r + 1), DW'(32'h100 + r));
    #1;
    n_tests++;
    if (ready !== 6'b001111) begin
      n_fail++;
      $display("FAIL all_six_ready0: got %b want 001111", ready);
    end
    @(posedge clk);
    #1;
    valid[3:0] = 4'b0000;
    ew = 4'b1111;
    ea = '{5'd1, 5'd2, 5'd3, 5'd4};
    ed = '{32'h100, 32'h101, 32'h102, 32'h103};
    for (int k = 0; k < NPORT; k++) begin
      n_tests++;
      if ({we_v[k], wa_v[k], wd_v[k]} !== {ew[k], ea[k], ed[k]}) begin
        n_fail++;
        $display("FAIL all_six_c0_port%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                 k, we_v[k], wa_v[k], wd_v[k], ew[k], ea[k], ed[k]);
      end
    end
    n_tests++;
    if (dut.ptr_q !== 3'd4) begin
      n_fail++;
      $display("FAIL all_six_ptr0: got %0d want 4", dut.ptr_q);
    end
    $display("[TB] all_six c0: we=%b ptr=%0d", we_v, dut.ptr_q);
    #1;
    n_tests++;
    if (ready !== 6'b110000) begin
      n_fail++;
      $display("FAIL all_six_ready1: got %b want 110000", ready);
    end
    @(posedge clk);
    #1;
    clear_req();
    ew = 4'b0011;
    ea = '{5'd5, 5'd6, 5'd0, 5'd0};
    ed = '{32'h104, 32'h105, 32'h0, 32'h0};
    for (int k = 0; k < NPORT; k++) begin
      n_tests++;
      if ({we_v[k], wa_v[k], wd_v[k]} !== {ew[k], ea[k], ed[k]}) begin
        n_fail++;
        $display("FAIL all_six_c1_port%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                 k, we_v[k], wa_v[k], wd_v[k], ew[k], ea[k], ed[k]);
      end
    end
    n_tests++;
    if (dut.ptr_q !== 3'd0) begin
      n_fail++;
      $display("FAIL all_six_ptr1: got %0d want 0", dut.ptr_q);
    end
    $display("[TB] all_six c1: we=%b ptr=%0d", we_v, dut.ptr_q);
  endtask

  task automatic test_conflict;
    do_reset();
    set_req(0, 5'd7, 32'h70);
    set_req(2, 5'd7, 32'h72);
    #1;
    n_tests++;
    if (ready !== 6'b000001) begin
      n_fail++;
      $display("FAIL conflict_ready0: got %b want 000001", ready);
    end
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    n_tests++;
    if ({we_v, wa0, wd0} !== {4'b0001, 5'd7, 32'h70}) begin
      n_fail++;
      $display("FAIL conflict_c0: got we=%b a=%0d d=%h want we=0001 a=7 d=70", we_v, wa0, wd0);
    end
    #1;
    n_tests++;
    if (ready !== 6'b000100) begin
      n_fail++;
      $display("FAIL conflict_ready1: got %b want 000100", ready);
    end
    @(posedge clk);
    #1;
    clear_req();
    n_tests++;
    if ({we_v, wa0, wd0} !== {4'b0001, 5'd7, 32'h72}) begin
      n_fail++;
      $display("FAIL conflict_c1: got we=%b a=%0d d=%h want we=0001 a=7 d=72", we_v, wa0, wd0);
    end
    n_tests++;
    if (dut.ptr_q !== 3'd3) begin
      n_fail++;
      $display("FAIL conflict_ptr: got %0d want 3", dut.ptr_q);
    end
    $display("[TB] conflict: we=%b a0=%0d d0=%h ptr=%0d", we_v, wa0, wd0, dut.ptr_q);
  endtask

  task automatic test_x0;
    do_reset();
    set_req(1, 5'd0, 32'h55);
    set_req(2, 5'd9, 32'h99);
    #1;
    n_tests++;
    if (ready !== 6'b000110) begin
      n_fail++;
      $display("FAIL x0_ready: got %b want 000110", ready);
    end
    @(posedge clk);
    #1;
    clear_req();
    ew = 4'b0001;
    ea = '{5'd9, 5'd0, 5'd0, 5'd0};
    ed = '{32'h99, 32'h0, 32'h0, 32'h0};
    for (int k = 0; k < NPORT; k++) begin
      n_tests++;
      if ({we_v[k], wa_v[k], wd_v[k]} !== {ew[k], ea[k], ed[k]}) begin
        n_fail++;
        $display("FAIL x0_port%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h",
                 k, we_v[k], wa_v[k], wd_v[k], ew[k], ea[k], ed[k]);
      end
    end
    n_tests++;
    if (dut.ptr_q !== 3'd3) begin
      n_fail++;
      $display("FAIL x0_ptr: got %0d want 3", dut.ptr_q);
    end
    $display("[TB] x0: we=%b a0=%0d ptr=%0d", we_v, wa0, dut.ptr_q);
  endtask

  task automatic test_reset_midflight;
    do_reset();
    for (int r = 0; r < NREQ; r++) set_req(r, AW'(r + 1), DW'(32'h200 + r));
    @(posedge clk);
    #1;
    n_tests++;
    if (we_v !== 4'b1111) begin
      n_fail++;
      $display("FAIL midrst_pre_we: got %b want 1111", we_v);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (ready !== '0) begin
      n_fail++;
      $display("FAIL midrst_ready: got %b want 000000", ready);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NPORT; k++) begin
      n_tests++;
      if ({we_v[k], wa_v[k], wd_v[k]} !== '0) begin
        n_fail++;
        $display("FAIL midrst_port%0d: got we=%b a=%0d d=%h want zeros", k, we_v[k], wa_v[k], wd_v[k]);
      end
    end
    n_tests++;
    if (dut.ptr_q !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_ptr: got %0d want 0", dut.ptr_q);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (ready !== 6'b001111) begin
      n_fail++;
      $display("FAIL midrst_resume_ready: got %b want 001111", ready);
    end
    @(posedge clk);
    #1;
    clear_req();
    n_tests++;
    if ({we_v, wa0, wd0} !== {4'b1111, 5'd1, 32'h200}) begin
      n_fail++;
      $display("FAIL midrst_resume: got we=%b a0=%0d d0=%h want we=1111 a0=1 d0=200", we_v, wa0, wd0);
    end
    $display("[TB] reset_midflight: we=%b ptr=%0d", we_v, dut.ptr_q);
  endtask

  task automatic test_random;
    int              seq;
    int              r;
    int              n_writes;
    logic [NREQ-1:0] acc;
    logic [AW-1:0]   a;
    logic [AW+DW-1:0] exp_e;
    logic            clash;
    do_reset();
    seq      = 0;
    n_writes = 0;
    for (int q = 0; q < NREQ; q++) begin
      wait_c[q] = 0;
      sbq[q].delete();
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int q = 0; q < NREQ; q++) begin
        if (!valid[q] && $urandom_range(0, 9) < 7) begin
          a = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom_range(1, 12));
          set_req(q, a, {4'(q), 28'(seq)});
          seq++;
        end
      end
      #1;
      acc = valid & ready;
      for (int q = 0; q < NREQ; q++) begin
        a = waddr[q*AW +: AW];
        if (acc[q]) begin
          wait_c[q] = 0;
          if (a != '0) sbq[q].push_back({a, wdata[q*DW +: DW]});
        end else if (valid[q] && a != '0) begin
          clash = 1'b0;
          for (int p = 0; p < NREQ; p++)
            if (p != q && valid[p] && waddr[p*AW +: AW] == a) clash = 1'b1;
          wait_c[q] = clash ? 0 : wait_c[q] + 1;
          n_tests++;
          if (wait_c[q] >= 2) begin
            n_fail++;
            $display("FAIL rand_starve r%0d cyc %0d: waited %0d cycles want <2", q, cyc, wait_c[q]);
          end
        end else begin
          wait_c[q] = 0;
        end
      end
      @(posedge clk);
      #1;
      valid = valid & ~acc;
      n_tests++;
      if (!(we_v inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111})) begin
        n_fail++;
        $display("FAIL rand_port_order cyc %0d: we=%b want contiguous from port0", cyc, we_v);
      end
      for (int k = 0; k < NPORT; k++) begin
        for (int j = k + 1; j < NPORT; j++) begin
          n_tests++;
          if (we_v[k] && we_v[j] && wa_v[k] == wa_v[j]) begin
            n_fail++;
            $display("FAIL rand_dup_addr cyc %0d: ports %0d,%0d both a=%0d want distinct", cyc, k, j, wa_v[k]);
          end
        end
        n_tests++;
        if (!we_v[k]) begin
          if ({wa_v[k], wd_v[k]} !== '0) begin
            n_fail++;
            $display("FAIL rand_idle_port%0d cyc %0d: a=%0d d=%h want 0", k, cyc, wa_v[k], wd_v[k]);
          end
        end else begin
          r = int'(wd_v[k][DW-1 -: 4]);
          if (r >= NREQ || sbq[r].size() == 0) begin
            n_fail++;
            $display("FAIL rand_unexpected port%0d cyc %0d: a=%0d d=%h want no write", k, cyc, wa_v[k], wd_v[k]);
          end else begin
            exp_e = sbq[r].pop_front();
            n_writes++;
            if ({wa_v[k], wd_v[k]} !== exp_e) begin
              n_fail++;
              $display("FAIL rand_write port%0d cyc %0d: got a=%0d d=%h want a=%0d d=%h",
                       k, cyc, wa_v[k], wd_v[k], exp_e[AW+DW-1 -: AW], exp_e[DW-1:0]);
            end
          end
        end
      end
      for (int q = 0; q < NREQ; q++) begin
        n_tests++;
        if (sbq[q].size() != 0) begin
          n_fail++;
          $display("FAIL rand_missing r%0d cyc %0d: %0d writes pending want 0", q, cyc, sbq[q].size());
          sbq[q].delete();
        end
      end
    end
    clear_req();
    $display("[TB] random: 10000 cycles, %0d writes matched", n_writes);
  endtask

  initial begin
    rst = 1'b1;
    clear_req();
    @(posedge clk);
    #1;
    test_reset();
    test_two_req();
    test_all_six();
    test_conflict();
    test_x0();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 6, number of execution-unit writeback requesters.
REQ-002 SHALL have parameter NPORT, fixed 4, number of register-file write ports driven.
REQ-003 SHALL have parameter AW, default 5, register address width; parameter DW, default 32, data width.
REQ-004 SHALL have port i_clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_valid, input, NREQ, per-requester writeback request.
REQ-007 SHALL have port i_waddr, input, NREQ*AW, packed destination addresses; requester r at bits [r*AW +: AW].
REQ-008 SHALL have port i_wdata, input, NREQ*DW, packed write data; requester r at bits [r*DW +: DW].
REQ-009 SHALL have port o_ready, output, NREQ, per-requester accept; combinational.
REQ-010 SHALL have ports o_we0..o_we3, output, 1 each, register-file write enables.
REQ-011 SHALL have ports o_waddr0..o_waddr3, output, AW each; o_wdata0..o_wdata3, output, DW each.

Function
REQ-012 SHALL accept a request in cycle t when i_valid[r] and o_ready[r] are both 1; the requester holds valid, addr and data stable until accepted.
REQ-013 SHALL treat a request with waddr 0 as a write to x0: o_ready=1 whenever valid and not in reset; consumes no port; nothing written.
REQ-014 SHALL scan requesters in rotating order ptr, ptr+1, ..., ptr+NREQ-1 (mod NREQ) and grant nonzero-address requests in that order until NPORT grants are made.
REQ-015 SHALL not grant a request whose nonzero waddr equals that of an earlier-granted request in the same cycle; that requester sees o_ready=0 and competes again next cycle.
REQ-016 SHALL map the k-th grant in scan order (k=0..3) to write port k.
REQ-017 SHALL register outputs: a grant to port k in cycle t drives o_wek=1 with its addr and data during cycle t+1 only (latency 1).
REQ-018 SHALL drive o_wek=0, o_waddrk=0 and o_wdatak=0 in any cycle following one with fewer than k+1 grants.
REQ-019 SHALL update ptr to (index of last nonzero-address grant + 1) mod NREQ after a cycle with at least one such grant; otherwise ptr is unchanged.
REQ-020 SHALL guarantee that a continuously valid requester with no address conflict is accepted within ceil(NREQ/NPORT) cycles.
REQ-021 SHALL never assert two o_we with the same o_waddr in one cycle.

Reset
REQ-022 SHALL, while i_rst=1, force o_ready=0 for all requesters, make no grants and accept nothing.
REQ-023 SHALL, on a clock edge with i_rst=1, set ptr=0 and all o_we, o_waddr and o_wdata to 0; this takes priority over any in-flight grant.
REQ-024 SHALL resume arbitration in the first cycle after i_rst falls, with ptr=0.

Structure
REQ-025 SHALL take XLEN (32), REG_AW (5), NUM_WB_PORTS (4) and NUM_WB_REQ (6) from the shared core package.
REQ-026 SHALL put the rotating scan, conflict check and port assignment in one combinational sub-module, wb_rr_pick; ptr and output registers stay in wb_arbiter.

Verification
REQ-027 SHALL cover: reset, then i_valid=6'b000011, r0 addr 3 data 0xA, r1 addr 4 data 0xB -> o_ready=000011; next cycle o_we0=1 addr 3 data 0xA, o_we1=1 addr 4 data 0xB, o_we2=o_we3=0; ptr=2.
REQ-028 SHALL cover: all 6 valid, distinct nonzero addrs, ptr=0 -> r0..r3 granted to ports 0..3, ptr becomes 4; next cycle r4, r5 granted to ports 0, 1, ptr becomes 0.
REQ-029 SHALL cover: r0 and r2 both addr 7, ptr=0 -> only r0 ready; next cycle r2 granted on port 0.
REQ-030 SHALL cover: r1 addr 0 and r2 addr 9 valid -> both ready; next cycle only o_we0=1, with addr 9.
REQ-031 SHALL cover: i_rst=1 asserted in the cycle after a 4-grant cycle -> after that edge all o_we=0 and ptr=0; with i_rst=1 and requests pending, o_ready=0.
REQ-032 SHALL cover: random valid/addr traffic for 10k cycles -> scoreboard confirms every accepted nonzero write appears exactly once, in order per requester, with REQ-020 and REQ-021 holding.
